alu_issue_seq: RTL
==================

# alu_issue_seq

Issue sequencer on the initiator side of `ALU_32bit`. It accepts one decoded SPARC format-2 (SETHI) or format-3 arithmetic/logic/shift instruction, reads operands from the register file, strobes the ALU, captures the result and flags, writes back `rd`, and maintains the integer condition codes (icc: N, Z, V, C). It sits between instruction fetch and the register file, one instruction in flight at a time.

## Interface
- No parameters; data width fixed at 32, register address at 5.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: SPARC instruction word.
- `instr_valid` in 1: `instr` is valid.
- `instr_ready` out 1: sequencer can accept; a transfer occurs when `instr_valid` and `instr_ready` are both high on a clock edge.
- `rf_rs1_addr`, `rf_rs2_addr` out 5 each: register-file read addresses. Data is returned one cycle later.
- `rf_rs1_data`, `rf_rs2_data` in 32 each: register-file read data.
- `rf_we` out 1: one-cycle write strobe.
- `rf_waddr` out 5: write address.
- `rf_wdata` out 32: write data.
- `alu_opcode` out 6: drives ALU `opcode`.
- `alu_a`, `alu_b` out 32 each: drive ALU `A_in` and `B_in`.
- `alu_carry` out 1: drives ALU `carry`; equals `icc_c`.
- `alu_en` out 1: drives ALU `ALUE`; one-cycle pulse.
- `alu_result` in 32: ALU `result`.
- `alu_n`, `alu_z`, `alu_v`, `alu_c` in 1 each: ALU flags.
- `icc` out 4: {N, Z, V, C} architectural condition codes.
- `illegal_instr` out 1: one-cycle pulse on an unsupported encoding.

## Operation
- Decode:
  - Format 3 (`instr[31:30]=2'b10`): `alu_opcode=op3=instr[24:19]`.
  - SETHI (`instr[31:30]=2'b00`, `instr[24:22]=3'b100`): `alu_opcode=6'b101010`, `alu_a=0`, `alu_b={10'b0,instr[21:0]}`.
- Legal op3 values:
  - `0x0x0x`/`0x0x1x` arithmetic and logic set: 000000–000111, 001000, 001100, 010000–010111, 011000, 011100.
  - Shifts: 100101, 100110, 100111.
  - Anything else pulses `illegal_instr` and returns to IDLE with no ALU strobe, no writeback and no icc change.
- Operand B:
  - `i=instr[13]=1`: B is `simm13` sign-extended to 32 bits.
  - Otherwise B is `rf_rs2_data` (`rs2=instr[4:0]`).
  - A is always `rf_rs1_data` (`rs1=instr[18:14]`).
- FSM states: IDLE, READ, EXEC, CAPT, WB.
  - IDLE -> READ on handshake (illegal encodings go IDLE -> IDLE with the pulse).
  - READ -> EXEC: operands latched into `alu_a`/`alu_b`.
  - EXEC -> CAPT: `alu_en=1` this cycle only.
  - CAPT -> WB: `alu_result` and flags sampled.
  - WB -> IDLE: `rf_we` pulse, icc update.
- Writeback: `rf_waddr=rd=instr[29:25]`. If `rd=0`, `rf_we` stays low (`%g0` is hardwired).
- icc update in WB, only when `op3[5:4]=2'b01` (cc variants):
  - Arithmetic (`op3[2]` sub / add family, i.e. `op3[3:0]` in {0000,1000,0100,1100}): icc <= {`alu_n`,`alu_z`,`alu_v`,`alu_c`}.
  - Logic: icc <= {`alu_n`,`alu_z`,0,0}.
  - SETHI, shifts and non-cc ops leave icc unchanged.

## Timing
- `instr_ready=1` only in IDLE.
- Handshake at edge 0 → `alu_en` high in cycle 2 → `rf_we` high in cycle 4 → `instr_ready` high again in cycle 5. Throughput is 1 instruction per 5 cycles.
- `alu_a`, `alu_b`, `alu_opcode` and `alu_carry` are stable from EXEC through CAPT.
- Reset values: state IDLE (`instr_ready=1` after release), `alu_en=0`, `rf_we=0`, `illegal_instr=0`, `alu_opcode=0`, `alu_a=0`, `alu_b=0`, `rf_waddr=0`, `rf_wdata=0`, `icc=4'b0000`.
- Reset mid-operation aborts immediately: no writeback and no ALU strobe.
- `instr_valid` outside IDLE is ignored; the upstream stage must hold the instruction until accepted.

## Configuration
- `ALU_SEQ_SHIFT_MASK_EN` defined: for shift op3 values (1001xx), `alu_b={27'b0,B[4:0]}`, giving SPARC shift-count semantics.
- Undefined: B is passed unmasked.

## Structure
- Package `sparc_alu_pkg` holds:
  - op3 localparams (`OP3_ADD`…`OP3_SRA`) and `ALU_OP_SETHI=6'b101010`.
  - The FSM state enum.
  - The icc bit indices.
- Sub-module `sparc_fmt3_decode`: combinational decode producing `alu_opcode`, legality, `use_imm`, extended immediate, `rs1`, `rs2`, `rd`, `sets_icc`, `is_logic`.

## Test plan
- ADDcc: r1=0x7FFFFFFF plus immediate 1, rd=3 → `rf_wdata=0x80000000` to r3 in cycle 4; icc=1010 (N, V set).
- SUBcc: r1=5, r2=5, rd=0 → no `rf_we`; icc Z=1 and C per ALU; no register changed.
- ANDcc after a carry-setting ADDcc: r1=0xF0, imm 0x0F → result 0, icc=0100 (V and C cleared).
- SETHI imm22=0x3FFFFF, rd=4 → r4=0xFFFFFC00; icc unchanged.
- SLL r1=1 by r2=33 → r1<<1=2 with `ALU_SEQ_SHIFT_MASK_EN`; 0 without it.
- op3=111111 → `illegal_instr` pulses once, `alu_en` and `rf_we` stay low, `instr_ready` is high the next cycle. Separately, `rst_n` asserted in EXEC → all outputs return to reset values with no write.

Source files
------------

// File: rtl/sparc_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sparc_alu_pkg
// Purpose : Shared op3 encodings, FSM state type and icc bit indices for the
//           SPARC ALU issue sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package sparc_alu_pkg;

  localparam logic [5:0] OP3_ADD     = 6'b000000;
  localparam logic [5:0] OP3_AND     = 6'b000001;
  localparam logic [5:0] OP3_OR      = 6'b000010;
  localparam logic [5:0] OP3_XOR     = 6'b000011;
  localparam logic [5:0] OP3_SUB     = 6'b000100;
  localparam logic [5:0] OP3_ANDN    = 6'b000101;
  localparam logic [5:0] OP3_ORN     = 6'b000110;
  localparam logic [5:0] OP3_XNOR    = 6'b000111;
  localparam logic [5:0] OP3_ADDX    = 6'b001000;
  localparam logic [5:0] OP3_SUBX    = 6'b001100;
  localparam logic [5:0] OP3_ADDCC   = 6'b010000;
  localparam logic [5:0] OP3_ANDCC   = 6'b010001;
  localparam logic [5:0] OP3_ORCC    = 6'b010010;
  localparam logic [5:0] OP3_XORCC   = 6'b010011;
  localparam logic [5:0] OP3_SUBCC   = 6'b010100;
  localparam logic [5:0] OP3_ANDNCC  = 6'b010101;
  localparam logic [5:0] OP3_ORNCC   = 6'b010110;
  localparam logic [5:0] OP3_XNORCC  = 6'b010111;
  localparam logic [5:0] OP3_ADDXCC  = 6'b011000;
  localparam logic [5:0] OP3_SUBXCC  = 6'b011100;
  localparam logic [5:0] OP3_SLL     = 6'b100101;
  localparam logic [5:0] OP3_SRL     = 6'b100110;
  localparam logic [5:0] OP3_SRA     = 6'b100111;

  localparam logic [5:0] ALU_OP_SETHI = 6'b101010;

  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_CAPT = 3'd3,
    ST_WB   = 3'd4
  } seq_state_e;

  function automatic logic op3_is_legal(input logic [5:0] op3);
    case (op3)
      OP3_ADD, OP3_AND, OP3_OR, OP3_XOR, OP3_SUB, OP3_ANDN, OP3_ORN, OP3_XNOR,
      OP3_ADDX, OP3_SUBX,
      OP3_ADDCC, OP3_ANDCC, OP3_ORCC, OP3_XORCC, OP3_SUBCC, OP3_ANDNCC,
      OP3_ORNCC, OP3_XNORCC, OP3_ADDXCC, OP3_SUBXCC,
      OP3_SLL, OP3_SRL, OP3_SRA: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_seq_if
// Purpose : Bundle of fetch handshake, register-file and ALU signals seen by
//           the issue sequencer (master) and its environment (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface alu_issue_seq_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_carry;
  logic        alu_en;
  logic [31:0] alu_result;
  logic        alu_n;
  logic        alu_z;
  logic        alu_v;
  logic        alu_c;
  logic [3:0]  icc;
  logic        illegal_instr;

  modport master (
    input  instr, instr_valid, rf_rs1_data, rf_rs2_data,
           alu_result, alu_n, alu_z, alu_v, alu_c,
    output instr_ready, rf_rs1_addr, rf_rs2_addr, rf_we, rf_waddr, rf_wdata,
           alu_opcode, alu_a, alu_b, alu_carry, alu_en, icc, illegal_instr
  );

  modport slave (
    output instr, instr_valid, rf_rs1_data, rf_rs2_data,
           alu_result, alu_n, alu_z, alu_v, alu_c,
    input  instr_ready, rf_rs1_addr, rf_rs2_addr, rf_we, rf_waddr, rf_wdata,
           alu_opcode, alu_a, alu_b, alu_carry, alu_en, icc, illegal_instr
  );
endinterface
`default_nettype wire

// File: rtl/sparc_fmt3_decode.sv
`default_nettype none
// ============================================================================
// Module  : sparc_fmt3_decode
// Purpose : Combinational decode of SPARC SETHI / format-3 ALU instructions.
// Revision: 1.0 - initial release
// ============================================================================
module sparc_fmt3_decode
  import sparc_alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [5:0]  o_alu_opcode,
  output logic        o_legal,
  output logic        o_use_imm,
  output logic [31:0] o_imm_ext,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_sets_icc,
  output logic        o_is_logic,
  output logic        o_is_sethi,
  output logic        o_is_shift
);

  logic       w_fmt3;
  logic       w_sethi;
  logic [5:0] w_op3;

  always_comb begin
    w_op3   = i_instr[24:19];
    w_fmt3  = (i_instr[31:30] == 2'b10);
    w_sethi = (i_instr[31:30] == 2'b00) && (i_instr[24:22] == 3'b100);

    o_rd         = i_instr[29:25];
    o_rs1        = i_instr[18:14];
    o_rs2        = i_instr[4:0];
    o_alu_opcode = w_op3;
    o_use_imm    = i_instr[13];
    o_imm_ext    = {{19{i_instr[12]}}, i_instr[12:0]};
    o_legal      = w_fmt3 && op3_is_legal(w_op3);
    o_sets_icc   = w_fmt3 && (w_op3[5:4] == 2'b01);
    // add/sub families all have op3[1:0] == 00; anything else in the cc set is logic
    o_is_logic   = (w_op3[1:0] != 2'b00);
    o_is_shift   = w_fmt3 && (w_op3[5:2] == 4'b1001);
    o_is_sethi   = w_sethi;

    if (w_sethi) begin
      o_alu_opcode = ALU_OP_SETHI;
      o_use_imm    = 1'b1;
      o_imm_ext    = {10'b0, i_instr[21:0]};
      o_legal      = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_seq
// Purpose : One-at-a-time issue sequencer: RF read, ALU strobe, capture,
//           writeback and icc maintenance for SPARC ALU instructions.
//           Optional: ALU_SEQ_SHIFT_MASK_EN masks shift counts to B[4:0].
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_seq
  import sparc_alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_seq_if.master io_seq
);

`ifdef ALU_SEQ_SHIFT_MASK_EN
  localparam logic SHIFT_MASK_EN = 1'b1;
`else
  localparam logic SHIFT_MASK_EN = 1'b0;
`endif

  seq_state_e  r_state;
  seq_state_e  w_state_nxt;

  logic [31:0] r_instr;
  logic [5:0]  r_alu_opcode;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [31:0] r_result;
  logic [3:0]  r_flags;
  logic [3:0]  r_icc;
  logic [4:0]  r_waddr;
  logic        r_illegal;

  logic [31:0] w_dec_instr;
  logic [5:0]  w_opcode;
  logic        w_legal;
  logic        w_use_imm;
  logic [31:0] w_imm_ext;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_sets_icc;
  logic        w_is_logic;
  logic        w_is_sethi;
  logic        w_is_shift;

  logic        w_ready;
  logic        w_accept;
  logic        w_alu_en;
  logic        w_wb;
  logic [31:0] w_b_sel;
  logic [31:0] w_b_final;

  // In IDLE decode the incoming word so RF addresses are presented on the
  // handshake edge; afterwards decode the held copy.
  assign w_dec_instr = (r_state == ST_IDLE) ? io_seq.instr : r_instr;

  sparc_fmt3_decode u_decode (
    .i_instr      (w_dec_instr),
    .o_alu_opcode (w_opcode),
    .o_legal      (w_legal),
    .o_use_imm    (w_use_imm),
    .o_imm_ext    (w_imm_ext),
    .o_rs1        (w_rs1),
    .o_rs2        (w_rs2),
    .o_rd         (w_rd),
    .o_sets_icc   (w_sets_icc),
    .o_is_logic   (w_is_logic),
    .o_is_sethi   (w_is_sethi),
    .o_is_shift   (w_is_shift)
  );

  assign w_b_sel   = w_use_imm ? w_imm_ext : io_seq.rf_rs2_data;
  assign w_b_final = (SHIFT_MASK_EN && w_is_shift) ? {27'b0, w_b_sel[4:0]} : w_b_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_alu_en    = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (io_seq.instr_valid) begin
          w_accept = 1'b1;
          if (w_legal) begin
            w_state_nxt = ST_READ;
          end
        end
      end
      ST_READ: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        w_alu_en    = 1'b1;
        w_state_nxt = ST_CAPT;
      end
      ST_CAPT: w_state_nxt = ST_WB;
      ST_WB: begin
        w_wb        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr      <= '0;
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_result     <= '0;
      r_flags      <= '0;
      r_icc        <= '0;
      r_waddr      <= '0;
      r_illegal    <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_instr <= io_seq.instr;
        r_waddr <= w_rd;
      end
      if (r_state == ST_READ) begin
        r_alu_opcode <= w_opcode;
        r_alu_a      <= w_is_sethi ? 32'h0 : io_seq.rf_rs1_data;
        r_alu_b      <= w_b_final;
      end
      if (r_state == ST_CAPT) begin
        r_result <= io_seq.alu_result;
        r_flags  <= {io_seq.alu_n, io_seq.alu_z, io_seq.alu_v, io_seq.alu_c};
      end
      // Logic ops define only N and Z; V and C are architecturally cleared.
      if (w_wb && w_sets_icc) begin
        r_icc <= w_is_logic ? {r_flags[ICC_N], r_flags[ICC_Z], 2'b00} : r_flags;
      end
    end
  end

  assign io_seq.instr_ready   = w_ready;
  assign io_seq.rf_rs1_addr   = w_rs1;
  assign io_seq.rf_rs2_addr   = w_rs2;
  assign io_seq.rf_we         = w_wb && (r_waddr != 5'd0);
  assign io_seq.rf_waddr      = r_waddr;
  assign io_seq.rf_wdata      = r_result;
  assign io_seq.alu_opcode    = r_alu_opcode;
  assign io_seq.alu_a         = r_alu_a;
  assign io_seq.alu_b         = r_alu_b;
  assign io_seq.alu_carry     = r_icc[ICC_C];
  assign io_seq.alu_en        = w_alu_en;
  assign io_seq.icc           = r_icc;
  assign io_seq.illegal_instr = r_illegal;

endmodule
`default_nettype wire
